// File: rtl/mpu6050_i2c_target_pkg.sv
// mpu6050_i2c_target_pkg: register addresses, default identity values and FSM states of the MPU6050 target.
package mpu6050_i2c_target_pkg;

    localparam logic [6:0] DEF_DEV_ADDR     = 7'h68;
    localparam logic [7:0] DEF_WHO_AM_I     = 8'h68;
    localparam logic [7:0] DEF_PWR_RST      = 8'h40;
    localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
    localparam logic [7:0] REG_WHO_AM_I     = 8'h75;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RACK, ST_IGNORE
    } state_e;

endpackage

// File: rtl/mpu6050_i2c_target_line_sync.sv
// mpu6050_i2c_target_line_sync: synchronises SCL/SDA and emits registered SCL edge and START/STOP strobes.
module mpu6050_i2c_target_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);
    logic [1:0] scl_s_q, sda_s_q;
    logic       scl_h_q, sda_h_q;

    // sda_h_q is the SDA value the strobes were computed from
    assign sda_o = sda_h_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_s_q    <= 2'b11;
            sda_s_q    <= 2'b11;
            scl_h_q    <= 1'b1;
            sda_h_q    <= 1'b1;
            scl_rise_o <= 1'b0;
            scl_fall_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
        end else begin
            scl_s_q    <= {scl_s_q[0], scl_i};
            sda_s_q    <= {sda_s_q[0], sda_i};
            scl_h_q    <= scl_s_q[1];
            sda_h_q    <= sda_s_q[1];
            scl_rise_o <= scl_s_q[1] & ~scl_h_q;
            scl_fall_o <= ~scl_s_q[1] & scl_h_q;
            start_o    <= scl_s_q[1] & scl_h_q & sda_h_q & ~sda_s_q[1];
            stop_o     <= scl_s_q[1] & scl_h_q & ~sda_h_q & sda_s_q[1];
        end
    end

endmodule

// File: rtl/mpu6050_i2c_target.sv
// mpu6050_i2c_target: I2C target modelling the MPU6050 PWR_MGMT_1 write and accel burst-read registers.
module mpu6050_i2c_target
    import mpu6050_i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
    parameter logic [7:0] WHO_AM_I = DEF_WHO_AM_I,
    parameter logic [7:0] PWR_RST  = DEF_PWR_RST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    input  logic [15:0] accel_x_in,
    input  logic [15:0] accel_y_in,
    input  logic [15:0] accel_z_in,
    output logic [7:0]  pwr_mgmt_1,
    output logic        reg_wr_pulse,
    output logic [7:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        busy
);
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d, ptr_q, ptr_d, pwr_q, pwr_d, wa_q, wa_d, wd_q, wd_d;
    logic [47:0] shadow_q, shadow_d;
    logic        low_q, low_d, busy_q, busy_d, rw_q, rw_d, ack_q, ack_d, pulse_q, pulse_d;
    logic        sda_s, rise, fall, start, stop, load;
    logic [7:0]  off, rd_byte;
    logic [2:0]  sel;

    mpu6050_i2c_target_line_sync u_sync (
        .clk(clk), .reset(reset), .scl_i(i2c_scl), .sda_i(i2c_sda), .sda_o(sda_s),
        .scl_rise_o(rise), .scl_fall_o(fall), .start_o(start), .stop_o(stop)
    );

    assign i2c_sda      = low_q ? 1'b0 : 1'bz;
    assign pwr_mgmt_1   = pwr_q;
    assign reg_wr_pulse = pulse_q;
    assign reg_wr_addr  = wa_q;
    assign reg_wr_data  = wd_q;
    assign busy         = busy_q;

    // shadow holds {x_h, x_l, y_h, y_l, z_h, z_l}, so 0x3B is the top byte
    assign off     = ptr_q - REG_ACCEL_XOUT_H;
    assign sel     = 3'd5 - off[2:0];
    assign rd_byte = ptr_q == REG_PWR_MGMT_1 ? pwr_q :
                     ptr_q == REG_WHO_AM_I   ? WHO_AM_I :
                     off < 8'd6              ? shadow_q[{sel, 3'b000} +: 8] : 8'h00;

    always_comb begin
        state_d = state_q; cnt_d = cnt_q; sh_d = sh_q; ptr_d = ptr_q; pwr_d = pwr_q;
        low_d = low_q; shadow_d = shadow_q; busy_d = busy_q; rw_d = rw_q; ack_d = ack_q;
        wa_d = wa_q; wd_d = wd_q; pulse_d = 1'b0; load = 1'b0;
        if (stop) begin
            state_d = ST_IDLE; low_d = 1'b0; busy_d = 1'b0;
        end else if (start) begin
            state_d = ST_ADDR; cnt_d = 4'd0; low_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA:
                    if (rise) begin
                        sh_d = {sh_q[6:0], sda_s}; cnt_d = cnt_q + 4'd1;
                    end else if (fall && cnt_q == 4'd8) begin
                        low_d = 1'b1;
                        state_d = state_q == ST_PTR ? ST_PTR_ACK : ST_WDATA_ACK;
                        if (state_q == ST_PTR) ptr_d = sh_q;
                        if (state_q == ST_ADDR) begin
                            state_d = sh_q[7:1] == DEV_ADDR ? ST_ADDR_ACK : ST_IGNORE;
                            low_d   = sh_q[7:1] == DEV_ADDR;
                            busy_d  = sh_q[7:1] == DEV_ADDR;
                            rw_d    = sh_q[0];
                            if (sh_q[7:1] == DEV_ADDR && sh_q[0])
                                shadow_d = {accel_x_in, accel_y_in, accel_z_in};
                        end
                    end
                ST_ADDR_ACK, ST_PTR_ACK:
                    if (fall) begin
                        load = state_q == ST_ADDR_ACK && rw_q;
                        state_d = state_q == ST_ADDR_ACK ? ST_PTR : ST_WDATA;
                        low_d = 1'b0; cnt_d = 4'd0;
                    end
                ST_WDATA_ACK:
                    if (fall) begin
                        state_d = ST_WDATA; low_d = 1'b0; cnt_d = 4'd0; pulse_d = 1'b1;
                        wa_d = ptr_q; wd_d = sh_q; ptr_d = ptr_q + 8'd1;
                        if (ptr_q == REG_PWR_MGMT_1) pwr_d = sh_q;
                    end
                ST_RDATA:
                    if (fall && cnt_q == 4'd7) begin
                        state_d = ST_RACK; low_d = 1'b0; ptr_d = ptr_q + 8'd1; ack_d = 1'b0;
                    end else if (fall) begin
                        sh_d = {sh_q[6:0], 1'b0}; low_d = ~sh_q[6]; cnt_d = cnt_q + 4'd1;
                    end
                ST_RACK:
                    if (rise && sda_s) state_d = ST_IGNORE;
                    else if (rise) ack_d = 1'b1;
                    else if (fall && ack_q) load = 1'b1;
                default: ;
            endcase
        end
        if (load) begin
            state_d = ST_RDATA; sh_d = rd_byte; low_d = ~rd_byte[7]; cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE; cnt_q <= '0; sh_q <= '0; ptr_q <= '0; pwr_q <= PWR_RST;
            low_q <= 1'b0; shadow_q <= '0; busy_q <= 1'b0; rw_q <= 1'b0; ack_q <= 1'b0;
            pulse_q <= 1'b0; wa_q <= '0; wd_q <= '0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; sh_q <= sh_d; ptr_q <= ptr_d; pwr_q <= pwr_d;
            low_q <= low_d; shadow_q <= shadow_d; busy_q <= busy_d; rw_q <= rw_d; ack_q <= ack_d;
            pulse_q <= pulse_d; wa_q <= wa_d; wd_q <= wd_d;
        end
    end

endmodule

// File: tb/tb_mpu6050_i2c_target.sv
// tb_mpu6050_i2c_target: bit-level I2C initiator driving the target, checked against a register-map model.
module tb_mpu6050_i2c_target;
    localparam int Q = 10;

    logic        clk = 1'b0, reset = 1'b1, scl = 1'b1, m_low = 1'b0;
    logic [15:0] ax = '0, ay = '0, az = '0;
    logic [7:0]  pwr, wa, wd;
    logic        pulse, busy;
    wire         sda;

    int checks = 0, failures = 0;
    int pulse_cnt = 0;
    logic [7:0] last_a = '0, last_d = '0;
    logic mon_en = 1'b0, drove = 1'b0;

    logic [7:0] mptr = 8'h00, mpwr = 8'h40;
    logic [7:0] mshadow [6];

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    mpu6050_i2c_target dut (
        .clk(clk), .reset(reset), .i2c_scl(scl), .i2c_sda(sda),
        .accel_x_in(ax), .accel_y_in(ay), .accel_z_in(az),
        .pwr_mgmt_1(pwr), .reg_wr_pulse(pulse), .reg_wr_addr(wa), .reg_wr_data(wd), .busy(busy)
    );

    always @(negedge clk) begin
        if (pulse) begin
            pulse_cnt <= pulse_cnt + 1;
            last_a <= wa;
            last_d <= wd;
        end
        if (mon_en && !m_low && sda == 1'b0) drove <= 1'b1;
    end

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        if (a >= 8'h3B && a <= 8'h40) return mshadow[a - 8'h3B];
        if (a == 8'h6B) return mpwr;
        if (a == 8'h75) return 8'h68;
        return 8'h00;
    endfunction

    task automatic tq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        m_low = 1'b0; tq(Q); scl = 1'b1; tq(Q); m_low = 1'b1; tq(Q); scl = 1'b0; tq(Q);
    endtask

    task automatic i2c_stop;
        m_low = 1'b1; tq(Q); scl = 1'b1; tq(Q); m_low = 1'b0; tq(Q);
    endtask

    task automatic wbit(input logic b);
        m_low = ~b; tq(Q); scl = 1'b1; tq(2 * Q); scl = 1'b0; tq(Q);
    endtask

    task automatic rbit(output logic b);
        m_low = 1'b0; tq(Q); scl = 1'b1; tq(Q); b = sda; tq(Q); scl = 1'b0; tq(Q);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(b);
        ack = ~b;
    endtask

    task automatic rbyte(output logic [7:0] d, input logic nack);
        logic [7:0] t;
        for (int i = 7; i >= 0; i--) rbit(t[i]);
        wbit(nack);
        d = t;
    endtask

    // START, 0xD0, pointer; optionally Sr + 0xD1. ok is the AND of all ACKs.
    task automatic set_ptr(input logic [7:0] p, input logic rd, output logic ok);
        logic a0, a1, a2;
        a2 = 1'b1;
        i2c_start; wbyte(8'hD0, a0); wbyte(p, a1);
        mptr = p;
        if (rd) begin
            i2c_start; wbyte(8'hD1, a2);
            for (int i = 0; i < 6; i++) mshadow[i] = i < 2 ? (i == 0 ? ax[15:8] : ax[7:0]) :
                                                   i < 4 ? (i == 2 ? ay[15:8] : ay[7:0]) :
                                                           (i == 4 ? az[15:8] : az[7:0]);
        end
        ok = a0 & a1 & a2;
    endtask

    task automatic do_reset;
        reset = 1'b1; scl = 1'b1; m_low = 1'b0; tq(3); reset = 1'b0; tq(3);
        mptr = 8'h00; mpwr = 8'h40;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (pwr !== 8'h40) begin failures++; $display("FAIL reset_pwr got=%h exp=40", pwr); end
        checks++; if (busy !== 1'b0 || pulse !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%b pulse=%b exp=0", busy, pulse); end
        checks++; if (wa !== 8'h00 || wd !== 8'h00) begin failures++; $display("FAIL reset_wr addr=%h data=%h exp=00", wa, wd); end
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda); end
    endtask

    task automatic test_pwr_write;
        logic ok, a;
        int pc;
        pc = pulse_cnt;
        set_ptr(8'h6B, 1'b0, ok);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pwr_busy got=%b exp=1", busy); end
        wbyte(8'h00, a);
        i2c_stop;
        mpwr = 8'h00; mptr = 8'h6C;
        checks++; if ((ok & a) !== 1'b1) begin failures++; $display("FAIL pwr_acks got=%b exp=1", ok & a); end
        checks++; if (pulse_cnt - pc !== 1) begin failures++; $display("FAIL pwr_pulses got=%0d exp=1", pulse_cnt - pc); end
        checks++; if (last_a !== 8'h6B || last_d !== 8'h00) begin failures++; $display("FAIL pwr_strobe got=%h/%h exp=6b/00", last_a, last_d); end
        checks++; if (pwr !== mpwr) begin failures++; $display("FAIL pwr_value got=%h exp=%h", pwr, mpwr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pwr_busy_stop got=%b exp=0", busy); end
    endtask

    task automatic burst(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        logic ok;
        logic [7:0] d, e;
        ax = x; ay = y; az = z;
        set_ptr(8'h3B, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL burst_acks got=%b exp=1", ok); end
        for (int i = 0; i < 6; i++) begin
            rbyte(d, i == 5);
            if (i == 0) begin
                ax = 16'($urandom); ay = 16'($urandom); az = 16'($urandom);
            end
            e = exp_read(mptr); mptr = mptr + 8'd1;
            checks++; if (d !== e) begin failures++; $display("FAIL burst_byte%0d got=%h exp=%h", i, d, e); end
        end
        i2c_stop;
    endtask

    task automatic test_burst_read;
        burst(16'h1234, 16'hABCD, 16'h8001);
        for (int k = 0; k < 2; k++) burst(16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic test_wrong_addr;
        logic a0, a1, a2;
        int pc;
        pc = pulse_cnt; drove = 1'b0; mon_en = 1'b1;
        i2c_start; wbyte(8'hD2, a0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrong_busy got=%b exp=0", busy); end
        wbyte(8'h6B, a1); wbyte(8'h55, a2);
        i2c_stop;
        mon_en = 1'b0;
        checks++; if ((a0 | a1 | a2) !== 1'b0) begin failures++; $display("FAIL wrong_acks got=%b%b%b exp=000", a0, a1, a2); end
        checks++; if (drove !== 1'b0) begin failures++; $display("FAIL wrong_drive got=%b exp=0", drove); end
        checks++; if (pulse_cnt !== pc || pwr !== mpwr) begin failures++; $display("FAIL wrong_effect pulses=%0d exp=%0d pwr=%h exp=%h", pulse_cnt, pc, pwr, mpwr); end
    endtask

    task automatic test_random_writes;
        logic ok, a;
        logic [7:0] p, d, e;
        int n, pc;
        for (int k = 0; k < 5; k++) begin
            p = k < 3 ? 8'h6A + 8'(k) : 8'($urandom);
            n = $urandom_range(1, 3);
            set_ptr(p, 1'b0, ok);
            checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wr_ptr_ack got=%b exp=1", ok); end
            for (int j = 0; j < n; j++) begin
                d = 8'($urandom); pc = pulse_cnt;
                wbyte(d, a);
                checks++;
                if (a !== 1'b1 || pulse_cnt - pc !== 1 || last_a !== mptr || last_d !== d) begin
                    failures++;
                    $display("FAIL wr_byte ack=%b pulses=%0d addr=%h data=%h exp=1/1/%h/%h", a, pulse_cnt - pc, last_a, last_d, mptr, d);
                end
                if (mptr == 8'h6B) mpwr = d;
                mptr = mptr + 8'd1;
            end
            i2c_stop;
            checks++; if (pwr !== mpwr) begin failures++; $display("FAIL wr_pwr got=%h exp=%h", pwr, mpwr); end
        end
        set_ptr(8'h6B, 1'b1, ok);
        rbyte(d, 1'b1);
        i2c_stop;
        e = exp_read(mptr);
        checks++; if (ok !== 1'b1 || d !== e) begin failures++; $display("FAIL wr_readback ack=%b got=%h exp=%h", ok, d, e); end
    endtask

    task automatic test_special_regs;
        logic ok;
        logic [7:0] d, e;
        set_ptr(8'h75, 1'b1, ok);
        for (int i = 0; i < 2; i++) begin
            rbyte(d, i == 1); e = exp_read(mptr); mptr = mptr + 8'd1;
            checks++; if (ok !== 1'b1 || d !== e) begin failures++; $display("FAIL who_byte%0d ack=%b got=%h exp=%h", i, ok, d, e); end
        end
        i2c_stop;
        set_ptr(8'hFF, 1'b1, ok);
        for (int i = 0; i < 2; i++) begin
            rbyte(d, i == 1); e = exp_read(mptr); mptr = mptr + 8'd1;
            checks++; if (ok !== 1'b1 || d !== e) begin failures++; $display("FAIL wrap_byte%0d ack=%b got=%h exp=%h", i, ok, d, e); end
        end
        i2c_stop;
        // continue from the wrapped pointer (now 0x01) with no pointer write
        ax = 16'h0000;
        i2c_start; wbyte(8'hD1, ok);
        rbyte(d, 1'b1);
        i2c_stop;
        e = exp_read(mptr); mptr = mptr + 8'd1;
        checks++; if (ok !== 1'b1 || d !== e) begin failures++; $display("FAIL wrap_cont ack=%b got=%h exp=%h", ok, d, e); end
    endtask

    task automatic test_reset_mid;
        logic ok, a, b;
        set_ptr(8'h6B, 1'b0, ok); wbyte(8'h01, a); i2c_stop;
        mpwr = 8'h01;
        checks++; if (pwr !== 8'h01) begin failures++; $display("FAIL rst_pre_pwr got=%h exp=01", pwr); end
        i2c_start;
        for (int i = 7; i >= 0; i--) wbit(i == 4 || i == 6 || i == 7);
        m_low = 1'b0; tq(6);
        checks++; if (sda !== 1'b0) begin failures++; $display("FAIL rst_ack_driven got=%b exp=0", sda); end
        reset = 1'b1; tq(1);
        checks++; if (sda !== 1'b1 || busy !== 1'b0 || pwr !== 8'h40) begin failures++; $display("FAIL rst_ack sda=%b busy=%b pwr=%h exp=1/0/40", sda, busy, pwr); end
        do_reset;
        set_ptr(8'h75, 1'b0, ok);
        i2c_start;
        for (int i = 7; i >= 0; i--) wbit(i == 4 || i == 6 || i == 7 || i == 0);
        rbit(b);
        checks++; if (b !== 1'b0 || sda !== 1'b0) begin failures++; $display("FAIL rst_bit_driven ack=%b sda=%b exp=0/0", b, sda); end
        reset = 1'b1; tq(1);
        checks++; if (sda !== 1'b1 || busy !== 1'b0 || pwr !== 8'h40) begin failures++; $display("FAIL rst_bit sda=%b busy=%b pwr=%h exp=1/0/40", sda, busy, pwr); end
        do_reset;
    endtask

    task automatic test_stop_partial;
        logic ok, a;
        logic [7:0] d;
        int pc;
        pc = pulse_cnt;
        set_ptr(8'h6B, 1'b0, ok);
        for (int i = 0; i < 4; i++) wbit(i[0]);
        i2c_stop;
        checks++; if (pulse_cnt !== pc || busy !== 1'b0 || pwr !== mpwr) begin failures++; $display("FAIL partial pulses=%0d busy=%b pwr=%h exp=%0d/0/%h", pulse_cnt, busy, pwr, pc, mpwr); end
        d = 8'($urandom);
        set_ptr(8'h6B, 1'b0, ok); wbyte(d, a); i2c_stop;
        mpwr = d;
        checks++; if ((ok & a) !== 1'b1 || pulse_cnt - pc !== 1 || pwr !== mpwr) begin failures++; $display("FAIL after_partial ack=%b pulses=%0d pwr=%h exp=1/1/%h", ok & a, pulse_cnt - pc, pwr, mpwr); end
    endtask

    task automatic test_back_to_back;
        logic ok, a;
        logic [7:0] d, e;
        d = 8'($urandom);
        set_ptr(8'h6B, 1'b0, ok); wbyte(d, a);
        mpwr = d; mptr = 8'h6C;
        set_ptr(8'h6B, 1'b1, ok);
        rbyte(e, 1'b1);
        i2c_stop;
        checks++; if ((ok & a) !== 1'b1 || e !== mpwr) begin failures++; $display("FAIL b2b ack=%b got=%h exp=%h", ok & a, e, mpwr); end
    endtask

    initial begin
        test_reset;
        test_pwr_write;
        test_burst_read;
        test_wrong_addr;
        test_random_writes;
        test_special_regs;
        test_reset_mid;
        test_stop_partial;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
